// File: rtl/mul_wb_pkg.sv
// mul_wb_pkg: shared types and default sizes for the multiply write-back buffer.
//   mul_wb_entry_t : one stored completion {rob_ptr, prf_val, prf_ptr, data}
//   *_DEF          : default widths and FIFO depth
package mul_wb_pkg;

  localparam int unsigned M_WIDTH_DEF  = 64;
  localparam int unsigned LG_ROB_DEF   = 6;
  localparam int unsigned LG_PRF_DEF   = 7;
  localparam int unsigned MUL_LAT_DEF  = 3;
  localparam int unsigned LG_DEPTH_DEF = 3;
  localparam int unsigned DEPTH_DEF    = 1 << LG_DEPTH_DEF;

  typedef struct packed {
    logic [LG_ROB_DEF-1:0]  rob_ptr;
    logic                   prf_val;
    logic [LG_PRF_DEF-1:0]  prf_ptr;
    logic [M_WIDTH_DEF-1:0] data;
  } mul_wb_entry_t;

endpackage

// File: rtl/mul_wb_buffer_if.sv
// mul_wb_buffer_if: write-back handshake from the completion buffer to the
// shared PRF-write / ROB-complete port.
//   master : buffer side   (drives valid + head fields, samples ready)
//   slave  : consumer side (samples valid + head fields, drives ready)
interface mul_wb_buffer_if
  import mul_wb_pkg::*;
#(
  parameter int unsigned M_WIDTH        = M_WIDTH_DEF,
  parameter int unsigned LG_ROB_ENTRIES = LG_ROB_DEF,
  parameter int unsigned LG_PRF_ENTRIES = LG_PRF_DEF
) ();

  logic                      wb_valid;
  logic                      wb_ready;
  logic [LG_ROB_ENTRIES-1:0] wb_rob_ptr;
  logic                      wb_prf_val;
  logic [LG_PRF_ENTRIES-1:0] wb_prf_ptr;
  logic [M_WIDTH-1:0]        wb_data;

  modport master (
    output wb_valid, wb_rob_ptr, wb_prf_val, wb_prf_ptr, wb_data,
    input  wb_ready
  );

  modport slave (
    input  wb_valid, wb_rob_ptr, wb_prf_val, wb_prf_ptr, wb_data,
    output wb_ready
  );

endinterface

// File: rtl/mul_wb_fifo.sv
// mul_wb_fifo: in-order FIFO of entry_t, 2^LG_DEPTH entries.
//   push/push_data : write an entry (accepted when not full, or full with a pop)
//   pop            : remove the head entry (ignored when empty)
//   head           : current head entry, all-zero when empty
//   full/empty     : status from the registered pointers
//   count          : number of stored entries
module mul_wb_fifo
  import mul_wb_pkg::*;
#(
  parameter type         entry_t  = mul_wb_entry_t,
  parameter int unsigned LG_DEPTH = LG_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  entry_t            push_data,
  input  logic              pop,
  output entry_t            head,
  output logic              full,
  output logic              empty,
  output logic [LG_DEPTH:0] count
);

  localparam int unsigned DEPTH = 1 << LG_DEPTH;

  entry_t            mem [DEPTH];
  logic [LG_DEPTH:0] wr_ptr;
  logic [LG_DEPTH:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Pointers carry one extra wrap bit: same low bits with differing MSBs is full.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[LG_DEPTH] != rd_ptr[LG_DEPTH]) &&
                   (wr_ptr[LG_DEPTH-1:0] == rd_ptr[LG_DEPTH-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop & ~empty;
  // A pop on a full FIFO frees the slot being written this same edge.
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr[LG_DEPTH-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[LG_DEPTH-1:0]] <= push_data;
  end

endmodule

// File: rtl/mul_wb_buffer.sv
// mul_wb_buffer: completion buffer behind the fixed-latency multiply/FP pipe.
//   clk, reset        : clock, asynchronous active-low reset
//   mul_go            : op launched into the pipe this cycle
//   mul_stall         : issue must hold off mul_go (all credits reserved)
//   mul_complete, mul_rob_ptr, mul_prf_val, mul_prf_ptr, mul_y : pipe result
//   wb (master)       : valid/ready write-back of the oldest stored result
//   occupancy         : stored entry count
//   overflow_err      : sticky, a completion was dropped on a full buffer
module mul_wb_buffer
  import mul_wb_pkg::*;
#(
  parameter int unsigned M_WIDTH        = M_WIDTH_DEF,
  parameter int unsigned LG_ROB_ENTRIES = LG_ROB_DEF,
  parameter int unsigned LG_PRF_ENTRIES = LG_PRF_DEF,
  parameter int unsigned MUL_LAT        = MUL_LAT_DEF,
  parameter int unsigned LG_DEPTH       = LG_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mul_go,
  output logic                      mul_stall,
  input  logic                      mul_complete,
  input  logic [LG_ROB_ENTRIES-1:0] mul_rob_ptr,
  input  logic                      mul_prf_val,
  input  logic [LG_PRF_ENTRIES-1:0] mul_prf_ptr,
  input  logic [M_WIDTH-1:0]        mul_y,
  mul_wb_buffer_if.master           wb,
  output logic [LG_DEPTH:0]         occupancy,
  output logic                      overflow_err
);

  localparam int unsigned DEPTH = 1 << LG_DEPTH;

  // Local entry type so width overrides carry into the FIFO storage.
  typedef struct packed {
    logic [LG_ROB_ENTRIES-1:0] rob_ptr;
    logic                      prf_val;
    logic [LG_PRF_ENTRIES-1:0] prf_ptr;
    logic [M_WIDTH-1:0]        data;
  } entry_t;

  entry_t            wr_entry;
  entry_t            head;
  logic              full;
  logic              empty;
  logic              valid;
  logic              pop;
  logic              go_acc;
  logic [LG_DEPTH:0] r_resv;
  logic [MUL_LAT:0]  inflight;

  always_comb begin
    wr_entry         = '0;
    wr_entry.rob_ptr = mul_rob_ptr;
    wr_entry.prf_val = mul_prf_val;
    wr_entry.prf_ptr = mul_prf_ptr;
    wr_entry.data    = mul_y;
  end

  mul_wb_fifo #(
    .entry_t  (entry_t),
    .LG_DEPTH (LG_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (mul_complete),
    .push_data (wr_entry),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (occupancy)
  );

  assign valid         = ~empty;
  assign pop           = valid & wb.wb_ready;
  assign wb.wb_valid   = valid;
  assign wb.wb_rob_ptr = head.rob_ptr;
  assign wb.wb_prf_val = head.prf_val;
  assign wb.wb_prf_ptr = head.prf_ptr;
  assign wb.wb_data    = head.data;

  // Stall looks only at the registered credit count, never at wb_ready.
  assign mul_stall = (r_resv == (LG_DEPTH+1)'(DEPTH));
  assign go_acc    = mul_go & ~mul_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_resv       <= '0;
      overflow_err <= 1'b0;
      inflight     <= '0;
    end else begin
      // Floor at zero so injected completions without a credit cannot wrap it.
      if (go_acc && !pop)
        r_resv <= r_resv + 1'b1;
      else if (!go_acc && pop && r_resv != '0)
        r_resv <= r_resv - 1'b1;
      if (mul_complete && full && !pop)
        overflow_err <= 1'b1;
      inflight <= (inflight << 1) | (MUL_LAT+1)'(go_acc);
    end
  end

  // Issue must respect the stall.
  a_go_under_stall: assert property (
    @(posedge clk) disable iff (!reset) mul_go |-> !mul_stall);

  // Every accepted op must come back exactly MUL_LAT+1 cycles later.
  a_fixed_latency: assert property (
    @(posedge clk) disable iff (!reset) inflight[MUL_LAT] |-> mul_complete);

endmodule

// File: tb/tb_mul_wb_buffer.sv
// tb_mul_wb_buffer: directed self-checking bench for mul_wb_buffer.
// A 4-stage shift register stands in for the multiplier; result fields are
// derived from a running sequence number so every expected head is known.
module tb_mul_wb_buffer;
  import mul_wb_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mul_go = 1'b0;
  logic        force_c = 1'b0;
  logic        mul_stall;
  logic        mul_complete;
  logic [5:0]  mul_rob_ptr;
  logic        mul_prf_val;
  logic [6:0]  mul_prf_ptr;
  logic [63:0] mul_y;
  logic [3:0]  occupancy;
  logic        overflow_err;
  logic [3:0]  go_pipe;
  logic [31:0] cnt = 0;
  logic [31:0] seq;
  int          errors = 0;
  int          checks = 0;

  mul_wb_buffer_if #(.M_WIDTH(64), .LG_ROB_ENTRIES(6), .LG_PRF_ENTRIES(7)) wb_if ();

  mul_wb_buffer #(
    .M_WIDTH        (64),
    .LG_ROB_ENTRIES (6),
    .LG_PRF_ENTRIES (7),
    .MUL_LAT        (3),
    .LG_DEPTH       (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mul_go       (mul_go),
    .mul_stall    (mul_stall),
    .mul_complete (mul_complete),
    .mul_rob_ptr  (mul_rob_ptr),
    .mul_prf_val  (mul_prf_val),
    .mul_prf_ptr  (mul_prf_ptr),
    .mul_y        (mul_y),
    .wb           (wb_if),
    .occupancy    (occupancy),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: go in cycle k gives complete in cycle k+4.
  always @(posedge clk or negedge reset) begin
    if (!reset) go_pipe <= '0;
    else        go_pipe <= {go_pipe[2:0], mul_go};
  end

  always @(posedge clk) begin
    if (reset && mul_complete) cnt <= cnt + 1;
  end

  assign mul_complete = go_pipe[3] | force_c;
  assign seq          = cnt + 5;
  assign mul_rob_ptr  = seq[5:0];
  assign mul_prf_val  = seq[0];
  assign mul_prf_ptr  = 7'(seq + 12);
  assign mul_y        = 64'h1234 + (64'(seq - 5) << 16);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected head for sequence number s (hand-derived field pattern).
  task automatic check_head(input string tag, input logic [31:0] s);
    logic [31:0] d;
    d = s - 5;
    chk({tag, "_valid"}, 64'(wb_if.wb_valid), 64'd1);
    chk({tag, "_rob"},   64'(wb_if.wb_rob_ptr), 64'(s & 32'h3f));
    chk({tag, "_pval"},  64'(wb_if.wb_prf_val), 64'(s & 32'h1));
    chk({tag, "_prf"},   64'(wb_if.wb_prf_ptr), 64'((s + 12) & 32'h7f));
    chk({tag, "_data"},  wb_if.wb_data, 64'h1234 + (64'(d) << 16));
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_valid"}, 64'(wb_if.wb_valid), 64'd0);
    chk({tag, "_stall"}, 64'(mul_stall), 64'd0);
    chk({tag, "_occ"},   64'(occupancy), 64'd0);
    chk({tag, "_ovf"},   64'(overflow_err), 64'd0);
    chk({tag, "_data"},  wb_if.wb_data, 64'd0);
    chk({tag, "_rob"},   64'(wb_if.wb_rob_ptr), 64'd0);
  endtask

  task automatic single_op(input string tag, input logic [31:0] s);
    wb_if.wb_ready = 1'b1;
    mul_go = 1'b1;
    step();
    mul_go = 1'b0;
    chk({tag, "_resv1"}, 64'(dut.r_resv), 64'd1);
    step(); step(); step();
    chk({tag, "_c4_valid"}, 64'(wb_if.wb_valid), 64'd0);
    step();
    check_head({tag, "_c5"}, s);
    step();
    chk({tag, "_c6_valid"}, 64'(wb_if.wb_valid), 64'd0);
    chk({tag, "_resv0"}, 64'(dut.r_resv), 64'd0);
    chk({tag, "_occ0"}, 64'(occupancy), 64'd0);
  endtask

  // Eight back-to-back ops with no drain; ends in the cycle after the last push.
  task automatic fill(input string tag);
    wb_if.wb_ready = 1'b0;
    mul_go = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 7) chk({tag, "_stall_c7"}, 64'(mul_stall), 64'd0);
    end
    chk({tag, "_stall_c8"}, 64'(mul_stall), 64'd1);
    mul_go = 1'b0;
    repeat (4) step();
    chk({tag, "_occ8"}, 64'(occupancy), 64'd8);
    chk({tag, "_ovf"}, 64'(overflow_err), 64'd0);
  endtask

  task automatic drain(input string tag, input logic [31:0] first, input int n);
    wb_if.wb_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check_head($sformatf("%s_%0d", tag, i), first + 32'(i));
      step();
    end
    wb_if.wb_ready = 1'b0;
    chk({tag, "_occ0"}, 64'(occupancy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wb_if.wb_ready = 1'b0;
    repeat (3) step();
    check_cleared("rst");
    reset = 1'b1;
    step();

    // Single op: fields 5/17/0x1234 appear one cycle after the completion.
    single_op("single", 32'd5);

    // Fill to credit: entries 6..13, stall from cycle 8.
    fill("fill");

    // Drain under stall; a go accepted right after the first pop completes cleanly.
    chk("drain_stall_c12", 64'(mul_stall), 64'd1);
    wb_if.wb_ready = 1'b1;
    check_head("drain_c12", 32'd6);
    step();
    chk("drain_stall_c13", 64'(mul_stall), 64'd0);
    check_head("drain_c13", 32'd7);
    mul_go = 1'b1;
    step();
    mul_go = 1'b0;
    for (int s = 8; s <= 14; s++) begin
      check_head($sformatf("drain_s%0d", s), 32'(s));
      step();
    end
    wb_if.wb_ready = 1'b0;
    chk("drain_end_valid", 64'(wb_if.wb_valid), 64'd0);
    chk("drain_end_ovf", 64'(overflow_err), 64'd0);
    chk("drain_end_resv", 64'(dut.r_resv), 64'd0);

    // Full FIFO, forced completion alongside a pop: entry 23 lands at the tail.
    fill("full2");
    force_c = 1'b1;
    wb_if.wb_ready = 1'b1;
    step();
    force_c = 1'b0;
    wb_if.wb_ready = 1'b0;
    chk("pushpop_occ", 64'(occupancy), 64'd8);
    chk("pushpop_ovf", 64'(overflow_err), 64'd0);
    drain("pushpop", 32'd16, 8);

    // Forced overflow: completion 32 is dropped and the error sticks.
    fill("full3");
    force_c = 1'b1;
    step();
    force_c = 1'b0;
    chk("ovf_set", 64'(overflow_err), 64'd1);
    chk("ovf_occ", 64'(occupancy), 64'd8);
    repeat (3) step();
    chk("ovf_sticky", 64'(overflow_err), 64'd1);
    drain("ovf", 32'd24, 8);
    chk("ovf_sticky_drained", 64'(overflow_err), 64'd1);

    // Reset mid-stream with three stored and two in flight.
    wb_if.wb_ready = 1'b0;
    mul_go = 1'b1;
    repeat (5) step();
    mul_go = 1'b0;
    repeat (2) step();
    chk("mid_occ3", 64'(occupancy), 64'd3);
    chk("mid_resv5", 64'(dut.r_resv), 64'd5);
    #2;
    reset = 1'b0;
    #1;
    check_cleared("async_rst");
    repeat (2) step();
    reset = 1'b1;
    step();
    check_cleared("post_rst");
    chk("post_rst_resv", 64'(dut.r_resv), 64'd0);
    single_op("after_rst", 32'd36);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_wb_buffer.md
# mul_wb_buffer

Completion buffer on the consumer side of the multiply/FP-add/FP-mul pipeline. That pipeline has fixed latency and no backpressure: every `go` yields exactly one `complete` pulse `MUL_LAT+1` cycles later. This block captures each result into an in-order FIFO and presents it to the shared PRF-write/ROB-complete port with a valid/ready handshake. It also issues a credit-based stall to the issue logic, so that no in-flight result can find the buffer full.

## Interface
- `M_WIDTH`, 64: result data width.
- `LG_ROB_ENTRIES`, 6: ROB pointer width.
- `LG_PRF_ENTRIES`, 7: PRF pointer width.
- `MUL_LAT`, 3: pipeline depth index; go-to-complete latency is `MUL_LAT+1` cycles.
- `LG_DEPTH`, 3: log2 of FIFO depth. DEPTH = 2^LG_DEPTH must be ≥ 2.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `mul_go` in 1: the issue logic launched an op into the multiplier this cycle.
- `mul_stall` out 1: issue must not assert `mul_go` while high.
- `mul_complete` in 1: multiplier result valid.
- `mul_rob_ptr` in LG_ROB_ENTRIES: ROB pointer of the result.
- `mul_prf_val` in 1: the result has a destination register.
- `mul_prf_ptr` in LG_PRF_ENTRIES: destination PRF pointer.
- `mul_y` in M_WIDTH: result data.
- `wb_valid` out 1: head entry presented.
- `wb_ready` in 1: downstream accepts the head entry this cycle.
- `wb_rob_ptr`, `wb_prf_val`, `wb_prf_ptr`, `wb_data` out: head entry fields, same widths as the inputs.
- `occupancy` out LG_DEPTH+1: FIFO entry count.
- `overflow_err` out 1: sticky error flag.

## Operation
- **FIFO write.** An entry is written on every cycle with `mul_complete=1`, regardless of `mul_prf_val`, because the ROB still needs the completion. Fields are stored verbatim.
- **FIFO read.** A pop happens when `wb_valid & wb_ready`. Entries leave in strict arrival order.
- **Credit counter `r_resv`** (0..DEPTH) counts in-flight ops plus stored entries.
  - +1 on `mul_go & !mul_stall`.
  - −1 on pop.
  - Both in the same cycle: unchanged.
- **Stall.** `mul_stall = (r_resv == DEPTH)`. This is combinational from the registered counter only; it has no path from `wb_ready`.
- **Protocol violations.**
  - `mul_go` while `mul_stall` is illegal. The counter does not increment, and a simulation assertion fires.
  - `mul_complete` while `occupancy == DEPTH` and no pop that cycle: the write is dropped and `overflow_err` is set. It stays set until reset.
- **Simultaneous write and pop:**
  - On a full FIFO the pop frees the slot, so the write succeeds and no error is raised.
  - On an empty FIFO, no bypass: the new entry appears at the head next cycle.
- **Pointers.** Read and write pointers are LG_DEPTH+1 bits and wrap naturally. Full is signalled by MSBs differing with the low bits equal; empty by full equality.
- **Reset (asynchronous, mid-operation allowed).** All state clears immediately and any in-flight or stored results are discarded. The upstream pipeline is reset by the same signal.
  - Outputs during and after reset: `wb_valid=0`, `mul_stall=0`, `occupancy=0`, `overflow_err=0`, `wb_*` data fields 0.

## Timing
- `mul_complete` at edge N gives `wb_valid=1` after edge N+1 when the FIFO was empty. The entry is pushed on edge N and read from the registered head, so the added latency is 1 cycle.
- Pop at edge N means the next entry is visible immediately after N, giving one pop per cycle of sustained throughput.
- `mul_stall` rises in the cycle after the reservation that fills the credit. It falls in the cycle after the pop that frees one.
- `wb_*` fields hold stable while `wb_valid & !wb_ready`.
- `occupancy` and `overflow_err` are registered.

## Structure
- **Shared package `mul_wb_pkg`** holds:
  - typedef `mul_wb_entry_t`, a packed struct {rob_ptr, prf_val, prf_ptr, data};
  - constants for the default widths and DEPTH.
- **Sub-module `mul_wb_fifo`** is a generic in-order FIFO of `mul_wb_entry_t` with push, pop, full, empty and count. The top level adds the credit counter, stall and error logic.

## Test plan
- **Single op.** `mul_go` at cycle 0, `mul_complete` with rob 5, prf 17, data 0x1234 at cycle 4, `wb_ready=1` → `wb_valid` only at cycle 5, with rob 5, prf 17, data 0x1234; `r_resv` returns to 0.
- **Fill to credit.** DEPTH=8, 8 back-to-back `mul_go` with `wb_ready=0` → `mul_stall` high from cycle 8; all 8 results are stored; `occupancy=8`; `overflow_err=0`.
- **Drain under stall.** From the full state, hold `wb_ready=1` → entries pop in order, 1 per cycle; `mul_stall` drops the cycle after the first pop; a `mul_go` accepted then completes with no error.
- **Full plus simultaneous push and pop.** FIFO full, forced `mul_complete` in the same cycle as a pop → `occupancy` stays 8 and the new entry lands at the tail.
- **Forced overflow.** Inject `mul_complete` with the FIFO full and `wb_ready=0` → write dropped; `overflow_err=1`, staying set until reset.
- **Reset mid-stream.** Assert reset asynchronously mid-stream with 3 entries stored and 2 in flight → outputs clear immediately; after release, `occupancy=0`, `mul_stall=0`, and a new op completes normally.
